// File: rtl/oser_gearbox_if.sv
// -----------------------------------------------------------------------------
// oser_gearbox_if
// Parallel-word input bus of the output serialiser gearbox.
//   IN_DATA  : LANES*RATIO parallel words, lane l at IN_DATA[l*RATIO +: RATIO]
//   IN_VALID : source offers IN_DATA
//   IN_READY : gearbox accepts IN_DATA at the next ECLK edge when IN_VALID=1
//   TRAIN    : training mode request (pattern replaces data while high)
// Modports: master = word source, slave = gearbox.
// -----------------------------------------------------------------------------
interface oser_gearbox_if #(
  parameter int RATIO = 7,
  parameter int LANES = 4
) ();
  logic [LANES*RATIO-1:0] IN_DATA;
  logic                   IN_VALID;
  logic                   IN_READY;
  logic                   TRAIN;

  modport master (output IN_DATA, output IN_VALID, output TRAIN, input IN_READY);
  modport slave  (input IN_DATA, input IN_VALID, input TRAIN, output IN_READY);
endinterface

// File: rtl/oser_gearbox.sv
// -----------------------------------------------------------------------------
// oser_gearbox
// Serialises RATIO-bit parallel words on LANES lanes into {rise, fall} bit
// pairs for a downstream DDR output cell, one pair per ECLK cycle. Each lane
// keeps a small bit buffer (time order, bit 0 oldest); all lanes share one
// fill count, so a single control path serves every lane.
// Ports:
//   ECLK     : edge clock, all state on its rising edge
//   RSTB     : synchronous active-high reset
//   in_bus   : slave side of oser_gearbox_if (IN_DATA/IN_VALID/IN_READY/TRAIN)
//   Q_RISE   : per-lane first-in-time bit of the current pair (registered)
//   Q_FALL   : per-lane second-in-time bit of the current pair (registered)
//   UNDERRUN : one-cycle pulse marking a starved (idle) slot after first data
// -----------------------------------------------------------------------------
module oser_gearbox #(
  parameter int               RATIO     = 7,
  parameter int               LANES     = 4,
  parameter bit               LSB_FIRST = 1'b1,
  parameter logic [1:0]       IDLE_PAT  = 2'b00,
  parameter logic [RATIO-1:0] TRAIN_PAT = 7'b1100011
) (
  input  logic              ECLK,
  input  logic              RSTB,
  oser_gearbox_if.slave     in_bus,
  output logic [LANES-1:0]  Q_RISE,
  output logic [LANES-1:0]  Q_FALL,
  output logic              UNDERRUN
);

  // A word is only appended when at most two bits remain, so RATIO+2 bits
  // is the deepest the buffer can ever get.
  localparam int BUF_W = RATIO + 2;
  localparam int FW    = $clog2(RATIO + 3);
  localparam logic [FW-1:0] F_TWO   = FW'(2);
  localparam logic [FW-1:0] F_RATIO = FW'(RATIO);

  logic [FW-1:0]    f_q, f_d;
  logic [BUF_W-1:0] buf_q [LANES];
  logic [BUF_W-1:0] buf_d [LANES];
  logic [LANES-1:0] rise_q, rise_d;
  logic [LANES-1:0] fall_q, fall_d;
  logic             armed_q, armed_d;
  logic             undr_q, undr_d;
  logic             room;
  logic             append;
  logic [FW-1:0]    f_ext;

  // Training wins over data but never blocks draining: it only takes the
  // same slot a data word would have taken.
  assign room            = (f_q <= F_TWO);
  assign in_bus.IN_READY = room && !in_bus.TRAIN;
  assign append          = room && (in_bus.TRAIN || in_bus.IN_VALID);
  assign f_ext           = append ? (f_q + F_RATIO) : f_q;

  always_comb begin
    logic [RATIO-1:0] word;
    logic [BUF_W-1:0] ord;
    logic [BUF_W-1:0] ext;
    rise_d  = '0;
    fall_d  = '0;
    f_d     = f_q;
    armed_d = armed_q | append;
    // Idle can only happen without an append, so armed_q is the right flag.
    undr_d  = armed_q && (f_ext < F_TWO);
    for (int l = 0; l < LANES; l++) begin
      word = in_bus.TRAIN ? TRAIN_PAT : in_bus.IN_DATA[l*RATIO +: RATIO];
      ord  = '0;
      for (int k = 0; k < RATIO; k++) begin
        ord[k] = LSB_FIRST ? word[k] : word[RATIO-1-k];
      end
      // Bits above the fill count are always zero, so OR-in is an append.
      ext = buf_q[l] | (append ? (ord << f_q) : '0);
      if (f_ext >= F_TWO) begin
        rise_d[l] = ext[0];
        fall_d[l] = ext[1];
        buf_d[l]  = ext >> 2;
      end else begin
        // A lone odd leftover bit stays at the head until the next word.
        rise_d[l] = IDLE_PAT[1];
        fall_d[l] = IDLE_PAT[0];
        buf_d[l]  = ext;
      end
    end
    if (f_ext >= F_TWO) begin
      f_d = f_ext - F_TWO;
    end
  end

  // ---- register stage: buffer, fill count and output pair ----
  always_ff @(posedge ECLK) begin
    if (RSTB) begin
      f_q     <= '0;
      armed_q <= 1'b0;
      undr_q  <= 1'b0;
      rise_q  <= '0;
      fall_q  <= '0;
      for (int l = 0; l < LANES; l++) begin
        buf_q[l] <= '0;
      end
    end else begin
      f_q     <= f_d;
      armed_q <= armed_d;
      undr_q  <= undr_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      for (int l = 0; l < LANES; l++) begin
        buf_q[l] <= buf_d[l];
      end
    end
  end

  assign Q_RISE   = rise_q;
  assign Q_FALL   = fall_q;
  assign UNDERRUN = undr_q;

endmodule

// File: tb/tb_oser_gearbox.sv
// -----------------------------------------------------------------------------
// tb_oser_gearbox
// Four gearbox instances (RATIO/LANES/bit order variants) checked every cycle
// against a bit-queue model, plus hand-computed sequences for the key cases.
// -----------------------------------------------------------------------------
module tb_oser_gearbox;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_ab = 1'b1;
  logic rst_cd = 1'b1;

  oser_gearbox_if #(.RATIO(7),  .LANES(1)) ifa ();
  oser_gearbox_if #(.RATIO(8),  .LANES(2)) ifb ();
  oser_gearbox_if #(.RATIO(2),  .LANES(3)) ifc ();
  oser_gearbox_if #(.RATIO(16), .LANES(3)) ifd ();

  logic [0:0] qra, qfa;
  logic [1:0] qrb, qfb;
  logic [2:0] qrc, qfc, qrd, qfd;
  logic       ua, ub, uc, ud;

  oser_gearbox #(.RATIO(7), .LANES(1), .LSB_FIRST(1'b1), .IDLE_PAT(2'b00),
                 .TRAIN_PAT(7'b1100011)) dut_a (
    .ECLK(clk), .RSTB(rst_ab), .in_bus(ifa), .Q_RISE(qra), .Q_FALL(qfa), .UNDERRUN(ua));
  oser_gearbox #(.RATIO(8), .LANES(2), .LSB_FIRST(1'b0), .IDLE_PAT(2'b00),
                 .TRAIN_PAT(8'h3C)) dut_b (
    .ECLK(clk), .RSTB(rst_ab), .in_bus(ifb), .Q_RISE(qrb), .Q_FALL(qfb), .UNDERRUN(ub));
  oser_gearbox #(.RATIO(2), .LANES(3), .LSB_FIRST(1'b1), .IDLE_PAT(2'b10),
                 .TRAIN_PAT(2'b10)) dut_c (
    .ECLK(clk), .RSTB(rst_cd), .in_bus(ifc), .Q_RISE(qrc), .Q_FALL(qfc), .UNDERRUN(uc));
  oser_gearbox #(.RATIO(16), .LANES(3), .LSB_FIRST(1'b1), .IDLE_PAT(2'b01),
                 .TRAIN_PAT(16'hA5C3)) dut_d (
    .ECLK(clk), .RSTB(rst_cd), .in_bus(ifd), .Q_RISE(qrd), .Q_FALL(qfd), .UNDERRUN(ud));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: one bit queue per lane ----------------
  bit         mq [16][$];
  bit         marm [4];
  logic [3:0] er [4];
  logic [3:0] ef [4];
  logic       eu [4];

  task automatic model_step(input int i, input int ratio, input int lanes, input bit lsbf,
                            input logic [1:0] idle, input logic [15:0] tpat,
                            input logic rst, input logic valid, input logic train,
                            input logic [63:0] data);
    logic [15:0] w;
    if (rst) begin
      for (int l = 0; l < 4; l++) mq[i*4+l].delete();
      marm[i] = 1'b0;
      er[i] = '0; ef[i] = '0; eu[i] = 1'b0;
    end else begin
      if ((mq[i*4].size() <= 2) && (train || valid)) begin
        marm[i] = 1'b1;
        for (int l = 0; l < lanes; l++) begin
          w = train ? tpat : 16'(data >> (l*ratio));
          for (int k = 0; k < ratio; k++) mq[i*4+l].push_back(lsbf ? w[k] : w[ratio-1-k]);
        end
      end
      er[i] = '0; ef[i] = '0;
      if (mq[i*4].size() >= 2) begin
        for (int l = 0; l < lanes; l++) begin
          er[i][l] = mq[i*4+l].pop_front();
          ef[i][l] = mq[i*4+l].pop_front();
        end
        eu[i] = 1'b0;
      end else begin
        for (int l = 0; l < lanes; l++) begin
          er[i][l] = idle[1];
          ef[i][l] = idle[0];
        end
        eu[i] = marm[i];
      end
    end
  endtask

  function automatic logic exp_ready(input int i, input logic train);
    return (mq[i*4].size() <= 2) && !train;
  endfunction

  // Model advances on every edge from the same inputs the DUTs see; the
  // outputs are compared shortly after the edge.
  always @(posedge clk) begin
    model_step(0, 7,  1, 1'b1, 2'b00, 16'h0063, rst_ab, ifa.IN_VALID, ifa.TRAIN, 64'(ifa.IN_DATA));
    model_step(1, 8,  2, 1'b0, 2'b00, 16'h003C, rst_ab, ifb.IN_VALID, ifb.TRAIN, 64'(ifb.IN_DATA));
    model_step(2, 2,  3, 1'b1, 2'b10, 16'h0002, rst_cd, ifc.IN_VALID, ifc.TRAIN, 64'(ifc.IN_DATA));
    model_step(3, 16, 3, 1'b1, 2'b01, 16'hA5C3, rst_cd, ifd.IN_VALID, ifd.TRAIN, 64'(ifd.IN_DATA));
    #1;
    chk("A_rise",  64'(qra), 64'(er[0][0:0]));
    chk("A_fall",  64'(qfa), 64'(ef[0][0:0]));
    chk("A_under", 64'(ua),  64'(eu[0]));
    chk("A_ready", 64'(ifa.IN_READY), 64'(exp_ready(0, ifa.TRAIN)));
    chk("B_rise",  64'(qrb), 64'(er[1][1:0]));
    chk("B_fall",  64'(qfb), 64'(ef[1][1:0]));
    chk("B_under", 64'(ub),  64'(eu[1]));
    chk("B_ready", 64'(ifb.IN_READY), 64'(exp_ready(1, ifb.TRAIN)));
    chk("C_rise",  64'(qrc), 64'(er[2][2:0]));
    chk("C_fall",  64'(qfc), 64'(ef[2][2:0]));
    chk("C_under", 64'(uc),  64'(eu[2]));
    chk("C_ready", 64'(ifc.IN_READY), 64'(exp_ready(2, ifc.TRAIN)));
    chk("D_rise",  64'(qrd), 64'(er[3][2:0]));
    chk("D_fall",  64'(qfd), 64'(ef[3][2:0]));
    chk("D_under", 64'(ud),  64'(eu[3]));
    chk("D_ready", 64'(ifd.IN_READY), 64'(exp_ready(3, ifd.TRAIN)));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // ---------------- directed sequences on A and B ----------------
  task automatic run_directed();
    bit [1:0] pa [8];
    bit       rdy_a [8];
    logic [13:0] got;
    int       ucount;
    pa    = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b11, 2'b11, 2'b11, 2'b00};
    rdy_a = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    tick(); tick();
    chk("rst_q_a",   64'({qra, qfa, ua}), 64'd0);
    chk("rst_ready", 64'(ifa.IN_READY), 64'd1);

    // 0x01 then 0x7F back-to-back (A); 0x80 / 0x01 MSB-first (B)
    @(negedge clk);
    rst_ab = 1'b0;
    ifa.IN_VALID = 1'b1; ifa.IN_DATA = 7'h01;
    ifb.IN_VALID = 1'b1; ifb.IN_DATA = 16'h0180;
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk($sformatf("seqA_pair%0d", e), 64'({qra, qfa}), 64'(pa[e-1]));
      chk($sformatf("seqA_under%0d", e), 64'(ua), 64'(e == 8));
      chk($sformatf("seqA_ready%0d", e), 64'(ifa.IN_READY), 64'(rdy_a[e-1]));
      if (e == 1) begin
        chk("seqB_e1", 64'({qrb, qfb}), 64'(4'b0100));
      end else if (e == 2 || e == 3) begin
        chk($sformatf("seqB_e%0d", e), 64'({qrb, qfb}), 64'(4'b0000));
      end else if (e == 4) begin
        chk("seqB_e4", 64'({qrb, qfb}), 64'(4'b0010));
      end
      @(negedge clk);
      if (e == 1) begin ifa.IN_DATA = 7'h7F; ifb.IN_VALID = 1'b0; end
      if (e == 4) ifa.IN_VALID = 1'b0;
    end

    // single word then starvation; leftover bit heads the next word
    rst_ab = 1'b1;
    tick();
    @(negedge clk);
    rst_ab = 1'b0; ifa.IN_VALID = 1'b1; ifa.IN_DATA = 7'h01;
    tick();
    chk("starve_e1", 64'({qra, qfa}), 64'(2'b10));
    @(negedge clk);
    ifa.IN_VALID = 1'b0;
    tick(); tick(); tick();
    chk("starve_e4_pair",  64'({qra, qfa}), 64'(2'b00));
    chk("starve_e4_under", 64'(ua), 64'd1);
    tick();
    chk("starve_e5_under", 64'(ua), 64'd1);
    @(negedge clk);
    ifa.IN_VALID = 1'b1; ifa.IN_DATA = 7'h7F;
    tick();
    chk("starve_resume_pair",  64'({qra, qfa}), 64'(2'b01));
    chk("starve_resume_under", 64'(ua), 64'd0);
    @(negedge clk);
    ifa.IN_VALID = 1'b0;

    // training pattern, gap-free, then drain into data
    rst_ab = 1'b1;
    tick();
    @(negedge clk);
    rst_ab = 1'b0; ifa.TRAIN = 1'b1; ifa.IN_VALID = 1'b1; ifa.IN_DATA = 7'h2A;
    #1;
    chk("train_ready", 64'(ifa.IN_READY), 64'd0);
    got = '0; ucount = 0;
    for (int e = 0; e < 7; e++) begin
      tick();
      got = {got[11:0], qra, qfa};
      ucount += int'(ua);
    end
    chk("train_stream", 64'(got), 64'(14'b11000111100011));
    chk("train_gapfree", 64'(ucount), 64'd0);
    repeat (5) tick();
    @(negedge clk);
    ifa.TRAIN = 1'b0;
    for (int e = 0; e < 20; e++) begin
      ifa.IN_DATA = 7'($urandom);
      tick();
      @(negedge clk);
    end
    ifa.IN_VALID = 1'b0;
    repeat (6) tick();

    // reset with bits buffered and IN_VALID still high
    @(negedge clk);
    rst_ab = 1'b1;
    tick();
    @(negedge clk);
    rst_ab = 1'b0; ifa.IN_VALID = 1'b1; ifa.IN_DATA = 7'h01;
    tick();
    @(negedge clk);
    rst_ab = 1'b1;
    tick();
    chk("midrst_q",     64'({qra, qfa, ua}), 64'd0);
    chk("midrst_ready", 64'(ifa.IN_READY), 64'd1);
    @(negedge clk);
    rst_ab = 1'b0; ifa.IN_VALID = 1'b0;
    ucount = 0;
    repeat (3) begin
      tick();
      ucount += int'(ua);
    end
    chk("midrst_no_under", 64'(ucount), 64'd0);
  endtask

  // ---------------- random streams on C (RATIO=2) and D (RATIO=16) ----------------
  task automatic run_random();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_cd = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      ifc.IN_VALID = (n >= 1000 && n < 1200) ? 1'b1 : ($urandom_range(0, 3) != 0);
      ifd.IN_VALID = (n >= 1000 && n < 1200) ? 1'b1 : ($urandom_range(0, 3) != 0);
      ifc.IN_DATA  = 6'($urandom);
      ifd.IN_DATA  = 48'({$urandom, $urandom});
      ifc.TRAIN    = ((n % 200) >= 150) && ((n % 200) < 170);
      ifd.TRAIN    = ((n % 300) >= 100) && ((n % 300) < 130);
      rst_cd       = (n == 700);
      @(negedge clk);
    end
    ifc.IN_VALID = 1'b0; ifd.IN_VALID = 1'b0;
    ifc.TRAIN = 1'b0; ifd.TRAIN = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    ifa.IN_VALID = 1'b0; ifa.TRAIN = 1'b0; ifa.IN_DATA = '0;
    ifb.IN_VALID = 1'b0; ifb.TRAIN = 1'b0; ifb.IN_DATA = '0;
    ifc.IN_VALID = 1'b0; ifc.TRAIN = 1'b0; ifc.IN_DATA = '0;
    ifd.IN_VALID = 1'b0; ifd.TRAIN = 1'b0; ifd.IN_DATA = '0;
    fork
      run_directed();
      run_random();
    join
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
